// File: rtl/alu_share_arb.sv
// Shares one external combinational ALU between NREQ requesters: grant, register operands, sample result, respond.
// Define ALU_ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module alu_share_arb #(
    parameter int NREQ = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [3*NREQ-1:0]    req_op,
    input  logic [32*NREQ-1:0]   req_a,
    input  logic [32*NREQ-1:0]   req_b,
    output logic [2:0]           alu_op,
    output logic [31:0]          alu_a,
    output logic [31:0]          alu_b,
    input  logic [31:0]          alu_out,
    input  logic                 alu_zero,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [1:0]           rsp_id,
    output logic [31:0]          rsp_data,
    output logic                 rsp_zero
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t      state_q, state_d;
    logic [2:0]  alu_op_q, alu_op_d;
    logic [31:0] alu_a_q, alu_a_d;
    logic [31:0] alu_b_q, alu_b_d;
    logic [1:0]  id_q, id_d;
    logic [31:0] rsp_data_q, rsp_data_d;
    logic        rsp_zero_q, rsp_zero_d;
    logic        rsp_valid_q, rsp_valid_d;
`ifndef ALU_ARB_FIXED_PRIO_EN
    logic [1:0]  ptr_q, ptr_d;
    int          idx;
`endif

    logic        win_found;
    logic [1:0]  win_idx;
    logic        grant_en;

    logic [2:0]  op_arr [NREQ];
    logic [31:0] a_arr  [NREQ];
    logic [31:0] b_arr  [NREQ];

    assign grant_en = (state_q == IDLE) && win_found && !rst;

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_req
            assign op_arr[gi]    = req_op[3*gi +: 3];
            assign a_arr[gi]     = req_a[32*gi +: 32];
            assign b_arr[gi]     = req_b[32*gi +: 32];
            assign req_ready[gi] = grant_en && (win_idx == 2'(gi));
        end
    endgenerate

    // Scan in reverse so the last hit is the first index in priority order.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
`ifdef ALU_ARB_FIXED_PRIO_EN
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req_valid[k]) begin
                win_found = 1'b1;
                win_idx   = 2'(k);
            end
        end
`else
        idx = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = (int'(ptr_q) + k) % NREQ;
            if (req_valid[idx]) begin
                win_found = 1'b1;
                win_idx   = 2'(idx);
            end
        end
`endif
    end

    always_comb begin
        state_d     = state_q;
        alu_op_d    = alu_op_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        id_d        = id_q;
        rsp_data_d  = rsp_data_q;
        rsp_zero_d  = rsp_zero_q;
        rsp_valid_d = rsp_valid_q;
`ifndef ALU_ARB_FIXED_PRIO_EN
        ptr_d       = ptr_q;
`endif
        case (state_q)
            IDLE: begin
                if (grant_en) begin
                    alu_op_d = op_arr[win_idx];
                    alu_a_d  = a_arr[win_idx];
                    alu_b_d  = b_arr[win_idx];
                    id_d     = win_idx;
                    state_d  = EXEC;
`ifndef ALU_ARB_FIXED_PRIO_EN
                    ptr_d    = (int'(win_idx) == NREQ - 1) ? 2'd0 : win_idx + 2'd1;
`endif
                end
            end
            EXEC: begin
                rsp_data_d  = alu_out;
                rsp_zero_d  = alu_zero;
                rsp_valid_d = 1'b1;
                state_d     = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                rsp_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            alu_op_q    <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            id_q        <= '0;
            rsp_data_q  <= '0;
            rsp_zero_q  <= 1'b0;
            rsp_valid_q <= 1'b0;
`ifndef ALU_ARB_FIXED_PRIO_EN
            ptr_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            alu_op_q    <= alu_op_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            id_q        <= id_d;
            rsp_data_q  <= rsp_data_d;
            rsp_zero_q  <= rsp_zero_d;
            rsp_valid_q <= rsp_valid_d;
`ifndef ALU_ARB_FIXED_PRIO_EN
            ptr_q       <= ptr_d;
`endif
        end
    end

    assign alu_op    = alu_op_q;
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = id_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_zero  = rsp_zero_q;

endmodule

// File: doc/alu_share_arb.md
# alu_share_arb

Round-robin arbiter and sequencer that shares one combinational ALU (3-bit op: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 SLT; 32-bit operands; `zero` flag) between up to four requesters, e.g. a datapath and a debug/test port. Each requester hands over one operation with a valid/ready handshake. The arbiter registers the operands, drives the ALU for one cycle, captures `out`/`zero`, and returns the result on a shared response channel tagged with the requester index.

## Interface
- `NREQ`, default 4: number of requesters, legal range 2..4.
- `clk`, input, 1: single clock; all state updates on its rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `req_valid`, input, NREQ: per-requester operation valid.
- `req_ready`, output, NREQ: per-requester accept; at most one bit set.
- `req_op`, input, 3*NREQ: ALU op of requester i at bits [3i+2:3i].
- `req_a`, input, 32*NREQ: operand A of requester i at bits [32i+31:32i].
- `req_b`, input, 32*NREQ: operand B of requester i, same packing as `req_a`.
- `alu_op`, output, 3: to ALU op input (registered).
- `alu_a`, output, 32: to ALU inA (registered).
- `alu_b`, output, 32: to ALU inB (registered).
- `alu_out`, input, 32: ALU result (combinational from `alu_op`/`alu_a`/`alu_b`).
- `alu_zero`, input, 1: ALU zero flag.
- `rsp_valid`, output, 1: response valid.
- `rsp_ready`, input, 1: response accept from consumer.
- `rsp_id`, output, 2: index of requester that owns the response.
- `rsp_data`, output, 32: captured `alu_out`.
- `rsp_zero`, output, 1: captured `alu_zero`.

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If any `req_valid` bit is set, assert `req_ready[g]` (combinational) for the winner g.
  - On that cycle's edge, latch `req_op`/`req_a`/`req_b` of g into `alu_op`/`alu_a`/`alu_b`, latch g into the id register, and go to EXEC.
  - With no valid request, stay in IDLE and hold all registers.
- EXEC: `req_ready` is 0. At the edge, capture `alu_out` into `rsp_data` and `alu_zero` into `rsp_zero`, set `rsp_valid`, and go to RESP.
- RESP:
  - `rsp_valid` = 1. `rsp_data`, `rsp_zero` and `rsp_id` stay stable until `rsp_ready` is high at an edge.
  - On that edge, clear `rsp_valid` and go to IDLE.
  - `req_ready` stays 0 for the whole state.
- Round-robin:
  - Pointer `ptr` is 2 bits, reset 0.
  - The winner is the first valid index scanning ptr, ptr+1, … modulo NREQ.
  - On a grant, `ptr` becomes (g+1) mod NREQ, wrapping NREQ-1 → 0.
- The op is passed through unchecked. Codes 101–111 complete normally with `rsp_data` = 0 and `rsp_zero` = 1, as the ALU produces.
- `alu_op`/`alu_a`/`alu_b` keep their last values outside EXEC; the ALU output is only sampled in EXEC.
- A requester that deasserts `req_valid` without a handshake is simply not granted. Requests are never partially accepted.

## Timing
- All outputs while `rst` is high and after its release: state IDLE, `req_ready` 0, `rsp_valid` 0, `rsp_id` 0, `rsp_data` 0, `rsp_zero` 0, `alu_op` 000, `alu_a` 0, `alu_b` 0, `ptr` 0.
- `req_ready` is forced 0 in any cycle where `rst` is high.
- Latency: handshake in cycle T, ALU driven in T+1, `rsp_valid` high in T+2.
- With `rsp_ready` tied high, there is one operation per 3 cycles; the next grant is possible at T+3.
- Backpressure: each cycle `rsp_ready` is low extends RESP by one cycle, with no data change.
- Reset mid-operation (EXEC or RESP) aborts the operation. The response is dropped, no `rsp_valid` pulse appears, and `ptr` returns to 0.
- A `req_valid` that rises in the same cycle the FSM enters IDLE is eligible in that cycle.

## Configuration
- `ALU_ARB_FIXED_PRIO_EN`:
  - Defined: fixed priority; the lowest valid index always wins, and `ptr` is neither used nor updated.
  - Undefined (default): round-robin as described above.

## Test plan
- Single op: req0 ADD with a=5, b=7 → `req_ready[0]` in T; `alu_op`=000, a=5, b=7 in T+1; `rsp_valid` in T+2 with data=12, zero=0, id=0.
- SUB equal: req2 a=0x10, b=0x10 → `rsp_data`=0, `rsp_zero`=1, id=2. SLT a=3, b=9 → data=1. Op 111 → data=0, zero=1.
- Round-robin: all four requesters held valid, `rsp_ready`=1 → grant order 0,1,2,3,0. With `ALU_ARB_FIXED_PRIO_EN` defined → 0,0,0.
- Backpressure: `rsp_ready`=0 for 5 cycles in RESP → `rsp_valid`, data and id stable and all `req_ready` 0 throughout. The release cycle completes the transfer, and the next grant is one cycle later.
- Reset in EXEC: assert `rst` for 1 cycle → next cycle all outputs at reset values, no response emitted, and the next grant follows the order starting from req0.
- Wrap: NREQ=2, last grant 1, both valid → grant 0.
